// File: rtl/bin_to_seg_multi.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) driving DIGITS 7-segment displays.
// Latency: start accepted at edge N -> done pulse and fresh outputs after edge N+WIDTH+1; idle again at N+WIDTH+2.
// Backpressure: none; start is honoured only in IDLE, and starts during SHIFT/DONE are dropped, not queued.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset; aborts any conversion and blanks the display
//   start     conversion request, sampled only while idle
//   bin       unsigned binary value [WIDTH-1:0], captured on an accepted start
//   busy      high while shifting
//   done      one-cycle pulse when bcd/seg/overflow are refreshed
//   overflow  captured value exceeded 10^DIGITS-1 (display shows the low DIGITS decimal digits)
//   bcd       packed BCD, nibble k = digit k (k=0 is ones)
//   seg       active-low {A..G} per digit, 7 bits per digit, digit k at [7k+6:7k]
//
// Build option: define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bin_to_seg_multi #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  // Largest value that fits in DIGITS decimal digits.
  localparam logic [31:0] LIMIT = pow10(DIGITS) - 32'd1;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0001100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [1:0]          state;
  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_pend;
  logic [7*DIGITS-1:0] seg_next;
  logic [31:0]         bin_ext;

  assign busy    = (state == ST_SHIFT);
  assign bin_ext = 32'(bin);

  // Add-3 correction: any digit >=5 would exceed 9 after doubling.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  // Scan from the top digit down; a digit is "leading" while everything above it is zero.
`ifdef LEAD_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    seg_next = '1;
    lead     = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (scratch[4*k +: 4] != 4'd0 || k == 0) lead = 1'b0;
      seg_next[7*k +: 7] = lead ? 7'b1111111 : seg7(scratch[4*k +: 4]);
    end
  end
`else
  always_comb begin
    seg_next = '1;
    for (int k = 0; k < DIGITS; k++) begin
      seg_next[7*k +: 7] = seg7(scratch[4*k +: 4]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
      seg      <= '1;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg    <= bin;
            scratch  <= '0;
            cnt      <= CNT_W'(WIDTH);
            ovf_pend <= (bin_ext > LIMIT);
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Top digit's carry is dropped, so scratch holds the value mod 10^DIGITS.
          scratch <= {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
          shreg   <= shreg << 1;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd      <= scratch;
          seg      <= seg_next;
          overflow <= ovf_pend;
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_seg_multi.sv
module tb_bin_to_seg_multi;

  localparam int W = 8;

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [7:0]  bin;
  logic        busy, done, overflow;
  logic [11:0] bcd;
  logic [20:0] seg;

  logic        start2;
  logic [7:0]  bin2;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd2;
  logic [13:0] seg2;

  bin_to_seg_multi #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .overflow(overflow), .bcd(bcd), .seg(seg)
  );

  bin_to_seg_multi #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .overflow(overflow2), .bcd(bcd2), .seg(seg2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  logic [6:0] glyph [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

  function automatic int p10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] m_bcd(input int v, input int nd);
    logic [31:0] r = 0;
    int m = v % p10(nd);
    for (int k = 0; k < nd; k++) r = r | (32'((m / p10(k)) % 10) << (4 * k));
    return r;
  endfunction

  function automatic logic [31:0] m_seg(input int v, input int nd);
    logic [31:0] r = 0;
    logic [6:0]  g;
    int m = v % p10(nd);
    for (int k = 0; k < nd; k++) begin
      g = glyph[(m / p10(k)) % 10];
      if (BLANK && k > 0 && (m / p10(k)) == 0) g = 7'b1111111;
      r = r | (32'(g) << (7 * k));
    end
    return r;
  endfunction

  // Model state: edge counter, next edge at which a start may be taken, pending conversion.
  int          e = 0, free_at = 0, acc = 0, pend_val = 0;
  bit          pend = 0;
  bit          x_done, x_busy, x_ovf;
  logic [31:0] x_bcd, x_seg;

  // Called just after a falling edge: drive inputs, advance one rising edge, compare at next falling edge.
  task automatic tick(input bit s, input int b, input bit r);
    start = s;
    bin   = 8'(b);
    reset = r;
    @(posedge clk);
    e++;
    if (r) begin
      pend = 0; free_at = e + 1;
      x_done = 0; x_busy = 0; x_ovf = 0; x_bcd = 0; x_seg = 32'h1FFFFF;
    end else begin
      x_done = 0;
      if (s && e >= free_at) begin
        pend = 1; acc = e; pend_val = b; free_at = e + W + 2;
      end
      if (pend && e == acc + W + 1) begin
        x_done = 1;
        x_bcd  = m_bcd(pend_val, 3);
        x_seg  = m_seg(pend_val, 3);
        x_ovf  = (pend_val > 999);
        pend   = 0;
      end
      x_busy = pend && (e <= acc + W - 1);
    end
    @(negedge clk);
    check("done", 32'(done), 32'(x_done));
    check("busy", 32'(busy), 32'(x_busy));
    check("bcd", 32'(bcd), x_bcd);
    check("seg", 32'(seg), x_seg);
    check("overflow", 32'(overflow), 32'(x_ovf));
  endtask

  typedef struct {
    int          v;
    logic [11:0] bcd;
    logic [20:0] seg_plain;
    logic [20:0] seg_blank;
  } vec_t;

  vec_t tbl [6];

  task automatic conv2(input int v, input logic [7:0] xb, input bit xo, input logic [13:0] xs);
    bit got = 0;
    start2 = 1'b1;
    bin2   = 8'(v);
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done2) got = 1;
    end
    check("d2_done_seen", 32'(got), 32'd1);
    check("d2_bcd", 32'(bcd2), 32'(xb));
    check("d2_overflow", 32'(overflow2), 32'(xo));
    check("d2_seg", 32'(seg2), 32'(xs));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat, ndone;
    bit  found;

    tbl[0] = '{255, 12'h255, 21'b0010010_0100100_0100100, 21'b0010010_0100100_0100100};
    tbl[1] = '{7,   12'h007, 21'b0000001_0000001_0001111, 21'b1111111_1111111_0001111};
    tbl[2] = '{0,   12'h000, 21'b0000001_0000001_0000001, 21'b1111111_1111111_0000001};
    tbl[3] = '{100, 12'h100, 21'b1001111_0000001_0000001, 21'b1001111_0000001_0000001};
    tbl[4] = '{40,  12'h040, 21'b0000001_1001100_0000001, 21'b1111111_1001100_0000001};
    tbl[5] = '{38,  12'h038, 21'b0000001_0000110_0000000, 21'b1111111_0000110_0000000};

    reset = 1'b1; start = 1'b0; bin = '0; start2 = 1'b0; bin2 = '0;
    @(negedge clk);
    tick(0, 0, 1);
    tick(0, 0, 1);
    check("reset_seg", 32'(seg), 32'h1FFFFF);
    check("reset_bcd", 32'(bcd), 32'h0);

    // Table of known conversions with exact latency measurement.
    for (int t = 0; t < 6; t++) begin
      tick(1, tbl[t].v, 0);
      found = 0; lat = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
        tick(0, $urandom_range(0, 255), 0);
        if (done) begin found = 1; lat = i; end
      end
      check("latency", 32'(lat), 32'(W + 1));
      check("tbl_bcd", 32'(bcd), 32'(tbl[t].bcd));
      check("tbl_seg", 32'(seg), 32'(BLANK ? tbl[t].seg_blank : tbl[t].seg_plain));
      check("tbl_overflow", 32'(overflow), 32'd0);
      tick(0, 0, 0);
      check("done_one_cycle", 32'(done), 32'd0);
    end

    // Reset held two cycles in mid-conversion: aborted, no done afterwards.
    tick(1, 200, 0);
    repeat (3) tick(0, 0, 0);
    tick(1, 99, 1);
    tick(1, 99, 1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'h000);
    check("midrst_seg", 32'(seg), 32'h1FFFFF);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0);
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);

    // Start held high with a new value every cycle: only accepted starts convert.
    for (int i = 0; i < 60; i++) tick(1, $urandom_range(0, 255), 0);
    // Sparse random starts.
    for (int i = 0; i < 400; i++) tick($urandom_range(0, 3) == 0, $urandom_range(0, 255), 0);
    repeat (12) tick(0, 0, 0);

    // Two-digit instance: overflow keeps low two digits, then clears.
    conv2(123, 8'h23, 1'b1, 14'b0010010_0000110);
    conv2(99,  8'h99, 1'b0, 14'b0001100_0001100);
    conv2(5,   8'h05, 1'b0, BLANK ? 14'b1111111_0100100 : 14'b0000001_0100100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
